full_sub_gate_level: RTL and testbench
======================================

// Module: full_sub_gate_level
// PURPOSE
//  Gate-level full subtractor: computes a - b - c (c = borrow-in).
//  Returns difference d and borrow-out.
//  Built as a ripple-borrow chain of 1-bit cells using only gate primitives (xor/and/or/not).
//  Outputs are registered, so the block drops into a clocked datapath as a 1-cycle stage.
// PARAMETERS
//  WIDTH  1  operand width in bits (>=1); WIDTH=1 is the classic 1-bit full subtractor
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      a/b/c qualify this cycle
//  a         in   WIDTH  minuend
//  b         in   WIDTH  subtrahend
//  c         in   1      borrow-in to bit 0
//  out_valid out  1      d/borrow hold the result of the input captured last cycle
//  d         out  WIDTH  difference, registered
//  borrow    out  1      borrow-out of MSB cell, registered
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Per-bit cell i, with bin0=c and bin(i+1)=bout(i):
//      d(i)    = a(i) ^ b(i) ^ bin(i)
//      bout(i) = (~a(i) & b(i)) | (~(a(i)^b(i)) & bin(i))
//  - borrow = bout(WIDTH-1). Arithmetic: {borrow,d} == (a - b - c) mod 2^(WIDTH+1).
//  - borrow=1 iff a < b + c (unsigned).
//  - 1-bit truth table (a b c -> d borrow):
//      000->00  001->11  010->11  011->01
//      100->10  101->00  110->00  111->11
//  - Datapath is pure combinational gates; no behavioural '-' operator.
//  - Latency is 1 cycle. On a rising clk with in_valid=1:
//      d/borrow <= cell outputs; out_valid <= 1.
//  - On a rising clk with in_valid=0: out_valid <= 0 and d/borrow hold their previous value.
//  - Back-to-back valid inputs give one result per cycle; there is no backpressure.
//  - Reset (rst_n=0, asynchronous) forces d=0, borrow=0, out_valid=0 immediately.
//    Reset asserted mid-stream discards the in-flight result.
//    The first valid input after rst_n deasserts produces a result on the following edge.
//  - Inputs with X/Z are not defined; the bench drives only known values.
// TESTING
//  - Exhaustive WIDTH=1: all 8 {a,b,c} combos with in_valid=1.
//    Each d/borrow matches the table one cycle later. Example: 001 -> d=1, borrow=1.
//  - Reset: assert rst_n=0 between clock edges while out_valid=1.
//    d=0, borrow=0, out_valid=0 immediately, without waiting for a clock edge.
//  - Hold: send a=1,b=0,c=0, then deassert in_valid for 3 cycles.
//    d=1, borrow=0 held; out_valid=0 for those 3 cycles.
//  - WIDTH=8 wrap: a=8'h00, b=8'h01, c=0 -> d=8'hFF, borrow=1.
//    a=8'h80, b=8'h7F, c=1 -> d=8'h00, borrow=0.
//  - WIDTH=8 streaming: 256 random valid vectors on consecutive cycles.
//    Every {borrow,d} == a-b-c (9-bit) exactly 1 cycle after its input; out_valid tracks in_valid delayed by 1.

Source files
------------

// File: rtl/full_sub_gate_level.sv
// Registered ripple-borrow subtractor {borrow,d} = a - b - c.
// It is built from 1-bit gate-primitive cells and has a one-cycle valid pipe.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic axb, na, naxb, gen, prop;

    xor g_axb  (axb, a, b);
    xor g_d    (d, axb, bin);
    not g_na   (na, a);
    and g_gen  (gen, na, b);
    // Borrow propagates through this bit only when a and b are equal.
    not g_naxb (naxb, axb);
    and g_prop (prop, naxb, bin);
    or  g_bout (bout, gen, prop);
endmodule

module full_sub_gate_level #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);
    localparam int STAGES = 1;

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] d_comb;
    logic [STAGES:0]  vld_pipe;

    assign bchain[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_sub_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bchain[i]),
            .d    (d_comb[i]),
            .bout (bchain[i+1])
        );
    end

    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            d                  <= '0;
            borrow             <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // The result holds when no new operands arrive.
            if (in_valid) begin
                d      <= d_comb;
                borrow <= bchain[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_full_sub_gate_level.sv
// Directed bench for full_sub_gate_level.
// It runs a 1-bit instance (truth table, hold) and an 8-bit instance (wrap, streaming).
module tb_full_sub_gate_level;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       ov1, d1, bo1;
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov8, bo8;
    logic [7:0] d8;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    full_sub_gate_level #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .d(d1), .borrow(bo1)
    );

    full_sub_gate_level #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
        .out_valid(ov8), .d(d8), .borrow(bo8)
    );

    task automatic test_reset;
        #1;
        total++;
        if ({ov1, d1, bo1, ov8, d8, bo8} !== 12'h0) begin
            bad++;
            $display("FAIL reset_init: got ov1=%b d1=%b bo1=%b ov8=%b d8=%h bo8=%b want all 0",
                     ov1, d1, bo1, ov8, d8, bo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Load nonzero results, then assert reset between edges.
        @(negedge clk);
        v1 = 1; a1 = 0; b1 = 1; c1 = 0;
        v8 = 1; a8 = 8'h00; b8 = 8'h05; c8 = 0;
        @(posedge clk);
        #2;
        total++;
        if ({ov1, d1, bo1} !== 3'b111 || {ov8, d8, bo8} !== {1'b1, 8'hFB, 1'b1}) begin
            bad++;
            $display("FAIL reset_preload: got ov1=%b d1=%b bo1=%b ov8=%b d8=%h bo8=%b want 1 1 1 / 1 fb 1",
                     ov1, d1, bo1, ov8, d8, bo8);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov1, d1, bo1, ov8, d8, bo8} !== 12'h0) begin
            bad++;
            $display("FAIL reset_async: got ov1=%b d1=%b bo1=%b ov8=%b d8=%h bo8=%b want all 0",
                     ov1, d1, bo1, ov8, d8, bo8);
        end
        // The first valid input after release appears on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        v1 = 1; a1 = 1; b1 = 0; c1 = 1;
        v8 = 1; a8 = 8'h10; b8 = 8'h01; c8 = 1;
        @(negedge clk);
        total++;
        if ({ov1, d1, bo1} !== 3'b100 || {ov8, d8, bo8} !== {1'b1, 8'h0E, 1'b0}) begin
            bad++;
            $display("FAIL reset_first: got ov1=%b d1=%b bo1=%b ov8=%b d8=%h bo8=%b want 1 0 0 / 1 0e 0",
                     ov1, d1, bo1, ov8, d8, bo8);
        end
        v1 = 0; v8 = 0;
    endtask

    task automatic test_truth_table;
        logic [7:0] d_tt  = 8'b1001_0110;
        logic [7:0] bo_tt = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v1 = 1; {a1, b1, c1} = i[2:0];
            @(negedge clk);
            total++;
            if (ov1 !== 1'b1 || d1 !== d_tt[i] || bo1 !== bo_tt[i]) begin
                bad++;
                $display("FAIL truth_%0d%0d%0d: got ov=%b d=%b borrow=%b want 1 %b %b",
                         i[2], i[1], i[0], ov1, d1, bo1, d_tt[i], bo_tt[i]);
            end
        end
        v1 = 0;
    endtask

    task automatic test_hold;
        @(negedge clk);
        v1 = 1; a1 = 1; b1 = 0; c1 = 0;
        @(negedge clk);
        v1 = 0; a1 = 0; b1 = 1; c1 = 1;
        total++;
        if ({ov1, d1, bo1} !== 3'b110) begin
            bad++;
            $display("FAIL hold_load: got ov=%b d=%b borrow=%b want 1 1 0", ov1, d1, bo1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({ov1, d1, bo1} !== 3'b010) begin
                bad++;
                $display("FAIL hold_cyc%0d: got ov=%b d=%b borrow=%b want 0 1 0", k, ov1, d1, bo1);
            end
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        v8 = 1; a8 = 8'h00; b8 = 8'h01; c8 = 0;
        @(negedge clk);
        total++;
        if ({ov8, bo8, d8} !== {1'b1, 1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL wrap_00m01: got ov=%b borrow=%b d=%h want 1 1 ff", ov8, bo8, d8);
        end
        a8 = 8'h80; b8 = 8'h7F; c8 = 1;
        @(negedge clk);
        total++;
        if ({ov8, bo8, d8} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL wrap_80m7f: got ov=%b borrow=%b d=%h want 1 0 00", ov8, bo8, d8);
        end
        v8 = 0;
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp_r;
        @(negedge clk);
        for (int k = 0; k <= 256; k++) begin
            if (k > 0) begin
                total++;
                if (ov8 !== 1'b1 || {bo8, d8} !== exp_r) begin
                    bad++;
                    $display("FAIL stream_%0d: got ov=%b {borrow,d}=%h want 1 %h", k - 1, ov8, {bo8, d8}, exp_r);
                end
            end
            if (k < 256) begin
                v8 = 1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
                exp_r = {1'b0, a8} - {1'b0, b8} - {8'h0, c8};
                @(negedge clk);
            end
        end
        v8 = 0;
        @(negedge clk);
        total++;
        if (ov8 !== 1'b0 || {bo8, d8} !== exp_r) begin
            bad++;
            $display("FAIL stream_tail: got ov=%b {borrow,d}=%h want 0 %h", ov8, {bo8, d8}, exp_r);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
